mac_operand_sequencer: RTL

- Transmit side of the MAC multiply datapath.
- Accepts one full-width operand pair (A, B) plus a precision config (single/dual/quad).
- Emits a stream of per-beat limb bundles in the lane format the multiply block consumes: one B limb per beat, A limbs placed on lanes A0..A3, beat index for downstream shift/accumulate.
- Sits between the MAC operand input registers and the multiply/accumulate stage.

---
 rtl/mac_operand_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mac_operand_sequencer.sv
// Operand sequencer for the MAC multiply datapath: splits an (A, B) pair into per-beat B limbs with fixed A lanes.
// Optional build macro MAC_SEQ_SKIP_ZERO_EN skips all-zero B limbs except the final one.
module mac_operand_sequencer #(
  parameter int MAC_CONF_WIDTH = 2,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_IN_WIDTH   = 4 * MAC_MIN_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MAC_CONF_WIDTH-1:0] in_cfg,
  input  logic [MAC_IN_WIDTH-1:0]   in_a,
  input  logic [MAC_IN_WIDTH-1:0]   in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MAC_CONF_WIDTH-1:0] out_cfg,
  output logic [MAC_MIN_WIDTH-1:0]  out_b2,
  output logic [MAC_MIN_WIDTH-1:0]  out_a0,
  output logic [MAC_MIN_WIDTH-1:0]  out_a1,
  output logic [MAC_MIN_WIDTH-1:0]  out_a2,
  output logic [MAC_MIN_WIDTH-1:0]  out_a3,
  output logic [1:0]                out_idx,
  output logic                      out_last
);

  localparam int W = MAC_MIN_WIDTH;

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_ISSUE = 1'b1;

  localparam logic [MAC_CONF_WIDTH-1:0] CFG_SINGLE = MAC_CONF_WIDTH'(0);
  localparam logic [MAC_CONF_WIDTH-1:0] CFG_DUAL   = MAC_CONF_WIDTH'(1);
  localparam logic [MAC_CONF_WIDTH-1:0] CFG_QUAD   = MAC_CONF_WIDTH'(2);

  logic                      state_q, state_d;
  logic [MAC_IN_WIDTH-1:0]   b_q, b_d;
  logic [1:0]                last_idx_q, last_idx_d;
  logic                      out_valid_q, out_valid_d;
  logic                      out_last_q, out_last_d;
  logic [1:0]                out_idx_q, out_idx_d;
  logic [W-1:0]              out_b2_q, out_b2_d;
  logic [W-1:0]              out_a0_q, out_a0_d;
  logic [W-1:0]              out_a1_q, out_a1_d;
  logic [W-1:0]              out_a2_q, out_a2_d;
  logic [W-1:0]              out_a3_q, out_a3_d;
  logic [MAC_CONF_WIDTH-1:0] out_cfg_q, out_cfg_d;

  logic [MAC_CONF_WIDTH-1:0] cfg_norm;
  logic [1:0]                last_in;
  logic [1:0]                first_idx;
  logic [1:0]                next_idx;
  logic [3:0]                nz_in;
  logic [3:0]                nz_q;
  logic                      accept;
  logic                      advance;

  // Lowest issuable limb index in [start, last_idx); falls back to last_idx, which is always issued.
  function automatic logic [1:0] pick_idx(input logic [3:0] nz, input logic [1:0] start,
                                          input logic [1:0] last_idx);
    logic [1:0] r;
    logic       found;
    r     = last_idx;
    found = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (!found && (j >= int'(start)) && (j < int'(last_idx)) && nz[j]) begin
        r     = 2'(j);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] limb_of(input logic [MAC_IN_WIDTH-1:0] b, input logic [1:0] k);
    logic [W-1:0] r;
    case (k)
      2'd0:    r = b[W-1:0];
      2'd1:    r = b[2*W-1:W];
      2'd2:    r = b[3*W-1:2*W];
      default: r = b[4*W-1:3*W];
    endcase
    return r;
  endfunction

`ifdef MAC_SEQ_SKIP_ZERO_EN
  assign nz_in = {|in_b[4*W-1:3*W], |in_b[3*W-1:2*W], |in_b[2*W-1:W], |in_b[W-1:0]};
  assign nz_q  = {|b_q[4*W-1:3*W],  |b_q[3*W-1:2*W],  |b_q[2*W-1:W],  |b_q[W-1:0]};
`else
  assign nz_in = 4'hF;
  assign nz_q  = 4'hF;
`endif

  assign in_ready = en & (state_q == STATE_IDLE);

  always_comb begin
    cfg_norm = ((in_cfg == CFG_DUAL) || (in_cfg == CFG_QUAD)) ? in_cfg : CFG_SINGLE;
    last_in  = (cfg_norm == CFG_QUAD) ? 2'd3 : ((cfg_norm == CFG_DUAL) ? 2'd1 : 2'd0);
    first_idx = pick_idx(nz_in, 2'd0, last_in);
    next_idx  = (out_idx_q == last_idx_q) ? last_idx_q
                                          : pick_idx(nz_q, out_idx_q + 2'd1, last_idx_q);
    accept  = in_valid & in_ready;
    advance = en & out_valid_q & out_ready & (state_q == STATE_ISSUE);

    state_d     = state_q;
    b_d         = b_q;
    last_idx_d  = last_idx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_idx_d   = out_idx_q;
    out_b2_d    = out_b2_q;
    out_a0_d    = out_a0_q;
    out_a1_d    = out_a1_q;
    out_a2_d    = out_a2_q;
    out_a3_d    = out_a3_q;
    out_cfg_d   = out_cfg_q;

    if (accept) begin
      // The first beat is built straight from the inputs so it appears one cycle after accept.
      state_d     = STATE_ISSUE;
      b_d         = in_b;
      last_idx_d  = last_in;
      out_cfg_d   = cfg_norm;
      out_valid_d = 1'b1;
      out_idx_d   = first_idx;
      out_b2_d    = limb_of(in_b, first_idx);
      out_last_d  = (first_idx == last_in);
      if (cfg_norm == CFG_QUAD) begin
        out_a0_d = in_a[W-1:0];
        out_a1_d = in_a[2*W-1:W];
        out_a2_d = in_a[3*W-1:2*W];
        out_a3_d = in_a[4*W-1:3*W];
      end else if (cfg_norm == CFG_DUAL) begin
        out_a0_d = '0;
        out_a1_d = '0;
        out_a2_d = in_a[W-1:0];
        out_a3_d = in_a[2*W-1:W];
      end else begin
        out_a0_d = '0;
        out_a1_d = '0;
        out_a2_d = in_a[W-1:0];
        out_a3_d = '0;
      end
    end else if (advance) begin
      if (out_last_q) begin
        state_d     = STATE_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end else begin
        out_idx_d  = next_idx;
        out_b2_d   = limb_of(b_q, next_idx);
        out_last_d = (next_idx == last_idx_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= STATE_IDLE;
      b_q         <= '0;
      last_idx_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
      out_b2_q    <= '0;
      out_a0_q    <= '0;
      out_a1_q    <= '0;
      out_a2_q    <= '0;
      out_a3_q    <= '0;
      out_cfg_q   <= '0;
    end else begin
      state_q     <= state_d;
      b_q         <= b_d;
      last_idx_q  <= last_idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_idx_q   <= out_idx_d;
      out_b2_q    <= out_b2_d;
      out_a0_q    <= out_a0_d;
      out_a1_q    <= out_a1_d;
      out_a2_q    <= out_a2_d;
      out_a3_q    <= out_a3_d;
      out_cfg_q   <= out_cfg_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_idx   = out_idx_q;
  assign out_b2    = out_b2_q;
  assign out_a0    = out_a0_q;
  assign out_a1    = out_a1_q;
  assign out_a2    = out_a2_q;
  assign out_a3    = out_a3_q;
  assign out_cfg   = out_cfg_q;

endmodule
